pump_controller: RTL and testbench



---
 rtl/pump_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_pump_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pump_controller.sv
// ---------------------------------------------------------------------------
// pump_controller
//
// Dispensing-transaction sequencer sitting directly upstream of the price
// accumulator. A start request clears the running price, waits for the
// settle time, then closes the pump relay. The fill ends on preset reached,
// tank full, operator stop, or a watchdog timeout (which latches FAULT
// until reset).
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | relay open, waiting for a start request
//   CLEAR   | one-cycle clear pulse to the accumulator, preset latched
//   ARM     | settle wait after the clear, relay still open
//   PUMP    | relay closed, watchdog running, stop conditions monitored
//   DONE    | relay open, price and stop reason held for display
//   FAULT   | watchdog expired; relay open, only reset leaves this state
//
// Ports
//   clk           system clock (1 MHz nominal)
//   rst           synchronous, active-high reset
//   btn_start     start button level (asynchronous, debounced)
//   btn_stop      stop button level (asynchronous, debounced)
//   tank_full     nozzle level sensor level (asynchronous), 1 = tank full
//   preset        target price in VND, 0 = no limit
//   price         running price read back from the accumulator
//   relay_manual  pump relay / accumulator enable
//   clear_price   one-cycle clear pulse to the accumulator
//   busy          high in CLEAR, ARM, PUMP
//   done          high in DONE
//   fault         high in FAULT
//   stop_reason   0 none, 1 preset reached, 2 tank full, 3 operator stop
// ---------------------------------------------------------------------------
module pump_controller #(
   parameter int unsigned SETTLE_CYCLES   = 1000,
   parameter int unsigned MAX_PUMP_CYCLES = 60000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_stop,
   input  logic        tank_full,
   input  logic [16:0] preset,
   input  logic [16:0] price,
   output logic        relay_manual,
   output logic        clear_price,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [1:0]  stop_reason
);

   localparam int unsigned ARM_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned WD_W  = $clog2(MAX_PUMP_CYCLES + 1);

   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SETTLE_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_PUMP_CYCLES - 1);

   localparam logic [1:0] RSN_NONE   = 2'd0;
   localparam logic [1:0] RSN_PRESET = 2'd1;
   localparam logic [1:0] RSN_FULL   = 2'd2;
   localparam logic [1:0] RSN_STOP   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ARM   = 3'd2,
      S_PUMP  = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [16:0]       preset_q, preset_d;
   logic [1:0]        reason_q, reason_d;

   // Two-flop synchronizers, a third copy for edge detection, and a
   // registered event pulse so a rising input acts on the 4th edge.
   logic start_s1_q, start_s2_q, start_s3_q, start_evt_q;
   logic stop_s1_q,  stop_s2_q,  stop_s3_q,  stop_evt_q;
   logic full_s1_q,  full_s2_q;

   logic relay_q, relay_d;
   logic clear_q, clear_d;
   logic busy_q,  busy_d;
   logic done_q,  done_d;
   logic fault_q, fault_d;

   // ---------------------------------------------------------------------
   // State register (also holds synchronizers, counters and output flops)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         arm_cnt_q   <= '0;
         wdog_q      <= '0;
         preset_q    <= '0;
         reason_q    <= RSN_NONE;
         start_s1_q  <= 1'b0;
         start_s2_q  <= 1'b0;
         start_s3_q  <= 1'b0;
         start_evt_q <= 1'b0;
         stop_s1_q   <= 1'b0;
         stop_s2_q   <= 1'b0;
         stop_s3_q   <= 1'b0;
         stop_evt_q  <= 1'b0;
         full_s1_q   <= 1'b0;
         full_s2_q   <= 1'b0;
         relay_q     <= 1'b0;
         clear_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         arm_cnt_q   <= arm_cnt_d;
         wdog_q      <= wdog_d;
         preset_q    <= preset_d;
         reason_q    <= reason_d;
         start_s1_q  <= btn_start;
         start_s2_q  <= start_s1_q;
         start_s3_q  <= start_s2_q;
         start_evt_q <= start_s2_q & ~start_s3_q;
         stop_s1_q   <= btn_stop;
         stop_s2_q   <= stop_s1_q;
         stop_s3_q   <= stop_s2_q;
         stop_evt_q  <= stop_s2_q & ~stop_s3_q;
         full_s1_q   <= tank_full;
         full_s2_q   <= full_s1_q;
         relay_q     <= relay_d;
         clear_q     <= clear_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      wdog_d    = wdog_q;
      preset_d  = preset_q;
      reason_d  = reason_q;

      unique case (state_q)
         S_IDLE: begin
            // A simultaneous stop cancels the start.
            if (start_evt_q && !stop_evt_q) begin
               state_d  = S_CLEAR;
               preset_d = preset;
               reason_d = RSN_NONE;
            end
         end

         S_CLEAR: begin
            state_d   = S_ARM;
            arm_cnt_d = '0;
         end

         S_ARM: begin
            if (stop_evt_q) begin
               state_d  = S_DONE;
               reason_d = RSN_STOP;
            end else if (arm_cnt_q == ARM_LAST) begin
               if (full_s2_q) begin
                  state_d  = S_DONE;
                  reason_d = RSN_FULL;
               end else begin
                  state_d = S_PUMP;
                  wdog_d  = '0;
               end
            end else begin
               arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
         end

         S_PUMP: begin
            wdog_d = wdog_q + WD_W'(1);
            if (wdog_q == WD_LAST) begin
               // Leave the counter at its limit rather than wrapping.
               state_d = S_FAULT;
               wdog_d  = wdog_q;
            end else if (stop_evt_q) begin
               state_d  = S_DONE;
               reason_d = RSN_STOP;
            end else if (full_s2_q) begin
               state_d  = S_DONE;
               reason_d = RSN_FULL;
            end else if ((preset_q != 17'd0) && (price >= preset_q)) begin
               state_d  = S_DONE;
               reason_d = RSN_PRESET;
            end
         end

         S_DONE: begin
            if (stop_evt_q) begin
               state_d  = S_IDLE;
               reason_d = RSN_NONE;
            end else if (start_evt_q) begin
               state_d  = S_CLEAR;
               preset_d = preset;
               reason_d = RSN_NONE;
            end
         end

         S_FAULT: begin
            state_d = S_FAULT;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode; decoded from the next state and registered so each
   // output changes on the same edge as the state it belongs to.
   // ---------------------------------------------------------------------
   always_comb begin
      relay_d = (state_d == S_PUMP);
      clear_d = (state_d == S_CLEAR);
      busy_d  = (state_d == S_CLEAR) || (state_d == S_ARM) || (state_d == S_PUMP);
      done_d  = (state_d == S_DONE);
      fault_d = (state_d == S_FAULT);
   end

   assign relay_manual = relay_q;
   assign clear_price  = clear_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign fault        = fault_q;
   assign stop_reason  = reason_q;

endmodule

// File: tb/tb_pump_controller.sv
module tb_pump_controller;

   localparam int SETTLE = 4;
   localparam int MAXP   = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_start = 1'b0;
   logic        btn_stop = 1'b0;
   logic        tank_full = 1'b0;
   logic [16:0] preset = 17'd0;
   logic [16:0] price = 17'd0;
   logic        relay_manual, clear_price, busy, done, fault;
   logic [1:0]  stop_reason;

   always #5 clk = ~clk;

   pump_controller #(.SETTLE_CYCLES(SETTLE), .MAX_PUMP_CYCLES(MAXP)) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
      .tank_full(tank_full), .preset(preset), .price(price),
      .relay_manual(relay_manual), .clear_price(clear_price), .busy(busy),
      .done(done), .fault(fault), .stop_reason(stop_reason)
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Accumulator: +1000 every 10 relay-high cycles, cleared by clear_price.
   int tick = 0;
   always @(posedge clk) begin
      if (clear_price === 1'b1) begin
         price <= 17'd0;
         tick  <= 0;
      end else if (relay_manual === 1'b1) begin
         if (tick == 9) begin
            tick  <= 0;
            price <= price + 17'd1000;
         end else begin
            tick <= tick + 1;
         end
      end
   end

   // Behavioural model. Input histories: h[0] is the value sampled at this
   // edge, h[k] the value sampled k edges earlier. A rise sampled at edge n
   // is acted on at edge n+3; tank_full acts two edges after sampling.
   localparam int M_IDLE = 0, M_CLEAR = 1, M_ARM = 2, M_PUMP = 3, M_DONE = 4, M_FAULT = 5;
   int          m_mode = M_IDLE;
   int          m_arm = 0, m_pump = 0, m_reason = 0;
   logic [16:0] m_preset = 17'd0;
   bit          hs[5], hp[5], hf[5];
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      bit sev, pev, full;
      for (int i = 4; i > 0; i--) begin
         hs[i] = hs[i-1];
         hp[i] = hp[i-1];
         hf[i] = hf[i-1];
      end
      hs[0] = (btn_start === 1'b1);
      hp[0] = (btn_stop === 1'b1);
      hf[0] = (tank_full === 1'b1);
      if (rst === 1'b1) begin
         for (int i = 0; i < 5; i++) begin
            hs[i] = 1'b0; hp[i] = 1'b0; hf[i] = 1'b0;
         end
         m_mode = M_IDLE; m_arm = 0; m_pump = 0; m_reason = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         sev  = hs[3] && !hs[4];
         pev  = hp[3] && !hp[4];
         full = hf[2];
         case (m_mode)
            M_IDLE: if (sev && !pev) begin
               m_mode = M_CLEAR; m_preset = preset; m_reason = 0;
            end
            M_CLEAR: begin
               m_mode = M_ARM; m_arm = 0;
            end
            M_ARM: begin
               m_arm++;
               if (pev) begin m_mode = M_DONE; m_reason = 3; end
               else if (m_arm == SETTLE) begin
                  if (full) begin m_mode = M_DONE; m_reason = 2; end
                  else begin m_mode = M_PUMP; m_pump = 0; end
               end
            end
            M_PUMP: begin
               m_pump++;
               if (m_pump == MAXP) m_mode = M_FAULT;
               else if (pev) begin m_mode = M_DONE; m_reason = 3; end
               else if (full) begin m_mode = M_DONE; m_reason = 2; end
               else if (m_preset != 0 && price >= m_preset) begin m_mode = M_DONE; m_reason = 1; end
            end
            M_DONE: begin
               if (pev) begin m_mode = M_IDLE; m_reason = 0; end
               else if (sev) begin m_mode = M_CLEAR; m_preset = preset; m_reason = 0; end
            end
            default: m_mode = M_FAULT;
         endcase
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      logic [6:0] exp_v, got_v;
      if (m_valid) begin
         exp_v = {m_mode == M_PUMP, m_mode == M_CLEAR,
                  (m_mode == M_CLEAR) || (m_mode == M_ARM) || (m_mode == M_PUMP),
                  m_mode == M_DONE, m_mode == M_FAULT, 2'(m_reason)};
         got_v = {relay_manual, clear_price, busy, done, fault, stop_reason};
         n_checks++;
         if (got_v === exp_v) n_pass++;
         else $display("FAIL cycle_outputs t=%0t: got %b expected %b (relay,clr,busy,done,fault,reason)",
                       $time, got_v, exp_v);
      end
   end

   // Event monitor, sampled just after each active edge.
   int          cy = 0, clr_cnt = 0, relay_cnt = 0, clr_cyc = 0;
   int          rise_cyc = 0, fall_cyc = 0, pchg_cyc = 0;
   logic        prev_relay = 1'b0;
   logic [16:0] prev_price = 17'd0;
   always @(posedge clk) begin
      #1;
      cy++;
      if (clear_price === 1'b1) begin clr_cnt++; clr_cyc = cy; end
      if (relay_manual === 1'b1) relay_cnt++;
      if (relay_manual === 1'b1 && prev_relay !== 1'b1) rise_cyc = cy;
      if (relay_manual !== 1'b1 && prev_relay === 1'b1) fall_cyc = cy;
      if (price != prev_price) pchg_cyc = cy;
      prev_relay = relay_manual;
      prev_price = price;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_start();
      btn_start = 1'b1; cyc(3); btn_start = 1'b0; cyc(1);
   endtask

   task automatic press_stop();
      btn_stop = 1'b1; cyc(3); btn_stop = 1'b0; cyc(1);
   endtask

   task automatic wait_relay(input logic val, input string name);
      int n = 0;
      while (relay_manual !== val && n < 200) begin cyc(1); n++; end
      chk(name, n < 200, 1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin cyc(1); n++; end
      chk(name, n < 200, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not end, got running expected finished");
      $fatal(1);
   end

   initial begin
      int c0, r0, n;
      logic [16:0] p0;

      cyc(2); rst = 1'b0; cyc(1);
      chk("reset_outputs", {relay_manual, clear_price, busy, done, fault, stop_reason}, 0);

      // Preset 3000, exact multiple.
      preset = 17'd3000;
      c0 = clr_cnt; r0 = relay_cnt;
      press_start();
      wait_done("preset3000_timeout");
      cyc(1);
      chk("clear_width", clr_cnt - c0, 1);
      chk("relay_rise_after_clear", rise_cyc - clr_cyc, SETTLE + 1);
      chk("relay_fall_after_price", fall_cyc - pchg_cyc, 1);
      chk("relay_high_cycles", relay_cnt - r0, 31);
      chk("final_price_3000", price, 3000);
      chk("reason_preset", stop_reason, 1);
      chk("model_mode_done", m_mode, M_DONE);
      cyc(15);
      chk("price_held", price, 3000);

      // Non-multiple preset, then stop back to IDLE.
      preset = 17'd2500;
      press_start();
      wait_done("preset2500_timeout");
      cyc(2);
      chk("price_2500_stop", price, 3000);
      chk("reason_2500", stop_reason, 1);
      press_stop();
      cyc(1);
      chk("idle_reason_clear", stop_reason, 0);
      chk("idle_done_low", done, 0);

      // Tank full mid-PUMP.
      preset = 17'd0;
      press_start();
      wait_relay(1'b1, "tank_relay_up");
      cyc(15);
      tank_full = 1'b1;
      n = 0;
      while (relay_manual === 1'b1 && n < 10) begin cyc(1); n++; end
      chk("tank_relay_within_4", n <= 4, 1);
      chk("reason_tank", stop_reason, 2);
      cyc(2);
      press_stop();

      // Tank already full at start: ends in ARM, relay never closes.
      r0 = relay_cnt;
      press_start();
      wait_done("tank_pre_timeout");
      chk("tank_pre_no_relay", relay_cnt - r0, 0);
      chk("tank_pre_reason", stop_reason, 2);
      tank_full = 1'b0;
      press_stop();

      // Operator stop in PUMP; preset change mid-PUMP ignored.
      preset = 17'd9000;
      press_start();
      wait_relay(1'b1, "stop_relay_up");
      cyc(15);
      preset = 17'd1000;
      cyc(20);
      chk("preset_change_ignored", relay_manual, 1);
      press_stop();
      chk("reason_stop", stop_reason, 3);
      chk("stop_relay_low", relay_manual, 0);
      press_stop();
      chk("back_idle", done, 0);

      // Start and stop rise together in IDLE.
      c0 = clr_cnt;
      btn_start = 1'b1; btn_stop = 1'b1;
      cyc(6);
      chk("simul_no_clear", clr_cnt - c0, 0);
      chk("simul_not_busy", busy, 0);
      btn_start = 1'b0; btn_stop = 1'b0;
      cyc(2);

      // Watchdog.
      preset = 17'd0;
      r0 = relay_cnt;
      press_start();
      n = 0;
      while (fault !== 1'b1 && n < 300) begin cyc(1); n++; end
      chk("wdog_timeout", n < 300, 1);
      chk("wdog_pump_cycles", relay_cnt - r0, MAXP);
      chk("wdog_relay_low", relay_manual, 0);
      chk("wdog_reason", stop_reason, 0);
      press_start();
      chk("fault_ignores_start", {fault, busy}, 2'b10);
      rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
      chk("fault_reset_outputs", {relay_manual, clear_price, busy, done, fault, stop_reason}, 0);

      // Reset mid-PUMP.
      press_start();
      wait_relay(1'b1, "rstmid_relay_up");
      cyc(20);
      c0 = clr_cnt;
      rst = 1'b1; cyc(1);
      p0 = price;
      chk("rstmid_relay_low", relay_manual, 0);
      chk("rstmid_not_busy", busy, 0);
      rst = 1'b0;
      cyc(5);
      chk("rstmid_price_kept", price, p0);
      chk("rstmid_no_clear", clr_cnt - c0, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 29) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 59) == 0) btn_stop = ~btn_stop;
         if ($urandom_range(0, 79) == 0) tank_full = ~tank_full;
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 4))
               0: preset = 17'd0;
               1: preset = 17'd1000;
               2: preset = 17'd2500;
               3: preset = 17'd3000;
               default: preset = 17'($urandom_range(1, 6000));
            endcase
         end
         rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; tank_full = 1'b0;
      cyc(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
